// File: rtl/tpu_pkg.sv
// Shared TPU definitions: counter modes and loop counter limits.
package tpu_pkg;

    typedef enum logic {CTR_WRAP, CTR_ONESHOT} ctr_mode_t;

    localparam int unsigned LOOP_CTR_MAX_CH  = 8;
    localparam int unsigned LOOP_CTR_MAX_LAT = 4;

endpackage

// File: rtl/loop_ctr_lane.sv
// One channel of the nested loop counter: count register, end compare,
// wrap/increment and the end-of-range event pipe.
module loop_ctr_lane
    import tpu_pkg::*;
#(
    parameter int unsigned COUNTER_WIDTH = 32,
    parameter int unsigned EVENT_LATENCY = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     load,
    input  logic                     enable,
    input  logic                     halt,
    input  logic                     hold,
    input  logic [COUNTER_WIDTH-1:0] end_val,
    input  logic                     carry_in,
    output logic                     carry_out,
    output logic [COUNTER_WIDTH-1:0] ctr_val,
    output logic                     ctr_event
);

    (* use_dsp = "yes" *) logic [COUNTER_WIDTH-1:0] cnt_q;
    logic [COUNTER_WIDTH-1:0] cnt_d;
    logic [COUNTER_WIDTH-1:0] end_q;
    logic                     at_end;

    assign at_end    = (cnt_q == end_q);
    assign carry_out = carry_in && at_end;
    assign ctr_val   = cnt_q;

    // Wrap is decided by compare, so an all-ones end value never relies on overflow.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = '0;
        end else if (carry_in && !halt && !hold) begin
            cnt_d = at_end ? '0 : cnt_q + COUNTER_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            end_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (load) begin
                end_q <= end_val;
            end
        end
    end

    if (EVENT_LATENCY == 0) begin : g_event_comb
        assign ctr_event = at_end;
    end else begin : g_event_pipe
        logic [EVENT_LATENCY-1:0] pipe_q;
        logic [EVENT_LATENCY-1:0] pipe_d;

        // The pipe ages only on enabled, non-halted cycles.
        always_comb begin
            pipe_d = pipe_q;
            if (load) begin
                pipe_d = '0;
            end else if (enable && !halt) begin
                pipe_d[0] = at_end;
                for (int unsigned s = 1; s < EVENT_LATENCY; s++) begin
                    pipe_d[s] = pipe_q[s-1];
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                pipe_q <= '0;
            end else begin
                pipe_q <= pipe_d;
            end
        end

        assign ctr_event = pipe_q[EVENT_LATENCY-1];
    end

endmodule

// File: rtl/loop_ctr.sv
// Multi-channel nested loop counter: carry-chained lanes, run mode and
// terminal-carry (done) tracking.
module loop_ctr
    import tpu_pkg::*;
#(
    parameter int unsigned COUNTER_WIDTH = 32,
    parameter int unsigned NUM_CH        = 3,
    parameter int unsigned EVENT_LATENCY = 2
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 enable,
    input  logic                                 load,
    input  ctr_mode_t                            mode,
    input  logic [NUM_CH-1:0][COUNTER_WIDTH-1:0] end_val,
    output logic [NUM_CH-1:0][COUNTER_WIDTH-1:0] ctr_val,
    output logic [NUM_CH-1:0]                    ctr_event,
    output logic                                 done
);

    ctr_mode_t         mode_q;
    logic              done_q;
    logic              done_d;
    logic              halt;
    logic              hold;
    logic              tc;
    logic [NUM_CH:0]   carry;

    assign carry[0] = enable;
    assign halt     = (mode_q == CTR_ONESHOT) && done_q;
    // One-shot runs park every lane on its end value instead of wrapping.
    assign hold     = (mode_q == CTR_ONESHOT) && carry[NUM_CH];
    assign tc       = carry[NUM_CH] && !load && !halt;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
        loop_ctr_lane #(
            .COUNTER_WIDTH (COUNTER_WIDTH),
            .EVENT_LATENCY (EVENT_LATENCY)
        ) u_lane (
            .clk       (clk),
            .rst_n     (rst_n),
            .load      (load),
            .enable    (enable),
            .halt      (halt),
            .hold      (hold),
            .end_val   (end_val[i]),
            .carry_in  (carry[i]),
            .carry_out (carry[i+1]),
            .ctr_val   (ctr_val[i]),
            .ctr_event (ctr_event[i])
        );
    end

    always_comb begin
        done_d = 1'b0;
        if (load) begin
            done_d = 1'b0;
        end else if (mode_q == CTR_ONESHOT) begin
            done_d = done_q || tc;
        end else begin
            done_d = tc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q <= CTR_WRAP;
            done_q <= 1'b0;
        end else begin
            done_q <= done_d;
            if (load) begin
                mode_q <= mode;
            end
        end
    end

    assign done = done_q;

endmodule
